// File: rtl/rb_bus_arbiter.sv
// rb_bus_arbiter: shares the single register-bank access port between NUM_REQ host
// interfaces (for example 0 = UART, 1 = I2C). Each host has a one-deep pending slot.
// Grants are round-robin, and a host may take an exclusive lock for multi-access streams.
//
// Access timing: req_en at cycle T, slot pending at T+1 (IDLE arbitrates), rb_reg_en at T+2
// (ISSUE), rb_data_read sampled at T+3 (CAPTURE), req_ack/req_rdata at T+4.
//
// Ports:
//   clk, resetb    clock; synchronous active-low reset
//   req_addr       per-requester address, slice i belongs to requester i
//   req_wdata      per-requester write data
//   req_en         per-requester single-cycle access strobe
//   req_we         per-requester write qualifier (1 = write)
//   req_lock       per-requester lock request/hold
//   req_ack        one-cycle completion pulse to the served requester
//   req_rdata      read data broadcast to all requesters, valid with req_ack
//   req_overflow   one-cycle pulse when a strobe is dropped because the slot is busy
//   rb_address, rb_data_write, rb_reg_en, rb_write_en  register-bank access port
//   rb_data_read   register-bank read data, valid the cycle after rb_reg_en
//   grant_id       index of the last granted requester
//   lock_valid     a lock is currently held
//   lock_timeout   one-cycle pulse when a lock is force-released
//
// Optional build macro RB_ARB_LOCK_TIMEOUT_EN: a held lock whose owner stays idle for
// LOCK_TIMEOUT cycles is force-released. Without it, locks are held indefinitely and
// lock_timeout is tied low.
module rb_bus_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_en,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_overflow,
  output logic [ADDR_W-1:0]         rb_address,
  output logic [DATA_W-1:0]         rb_data_write,
  output logic                      rb_reg_en,
  output logic                      rb_write_en,
  input  logic [DATA_W-1:0]         rb_data_read,
  output logic [1:0]                grant_id,
  output logic                      lock_valid,
  output logic                      lock_timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || LOCK_TIMEOUT < 1) begin : gen_bad_params
    $error("rb_bus_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Pending slots
  logic [NUM_REQ-1:0] slot_full_q, slot_full_d;
  logic [NUM_REQ-1:0] slot_we_q;
  logic [ADDR_W-1:0]  slot_addr_q  [NUM_REQ];
  logic [DATA_W-1:0]  slot_wdata_q [NUM_REQ];
  logic [NUM_REQ-1:0] accept, free_oh, overflow_d;

  // Arbitration
  logic [1:0]         ptr_q, winner_q, pick, ptr_next;
  logic               found, grant;
  logic [2:0]         idx;
  logic [NUM_REQ-1:0] owner_oh, win_oh, pick_oh, eligible;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_wdata;
  logic               pick_we;
  logic               win_we_q;

  // Lock
  logic               lock_valid_q, lock_valid_d;
  logic [1:0]         lock_owner_q;
  logic               lock_hold, lock_acquire, force_release;
  logic [NUM_REQ-1:0] lock_block;

  // Output registers
  logic [NUM_REQ-1:0] req_ack_q, req_overflow_q;
  logic [DATA_W-1:0]  req_rdata_q, rb_data_write_q;
  logic [ADDR_W-1:0]  rb_address_q;
  logic               rb_reg_en_q, rb_write_en_q;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_oh[i] = (lock_owner_q == 2'(i));
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) win_oh[i] = (winner_q == 2'(i));
  end

  // The lock stops gating eligibility in the very cycle req_lock[owner] falls, so a waiting
  // requester is issued the cycle after; lock_valid itself drops one cycle later.
  assign lock_hold = lock_valid_q & (|(req_lock & owner_oh));
  assign eligible  = lock_hold ? (slot_full_q & owner_oh) : slot_full_q;

  // Round-robin: first eligible slot at or after the pointer, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + 3'(k);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (idx == 3'(i)) && eligible[i]) begin
          found = 1'b1;
          pick  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) pick_oh[i] = (pick == 2'(i));
  end

  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_addr  = slot_addr_q[i];
        pick_wdata = slot_wdata_q[i];
        pick_we    = slot_we_q[i];
      end
    end
  end

  assign ptr_next = (pick == 2'(NUM_REQ - 1)) ? 2'd0 : pick + 2'd1;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          grant   = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // A slot being issued this cycle frees up in time to take a new strobe.
  assign free_oh     = (state_q == StIssue) ? win_oh : '0;
  assign accept      = req_en & (~slot_full_q | free_oh);
  assign overflow_d  = req_en & ~accept;
  assign slot_full_d = accept | (slot_full_q & ~free_oh);

  assign lock_acquire = grant & (|(pick_oh & req_lock & ~lock_block));

  always_comb begin
    lock_valid_d = lock_valid_q;
    if (lock_valid_q && (!lock_hold || force_release)) lock_valid_d = 1'b0;
    if (lock_acquire) lock_valid_d = 1'b1;
  end

`ifdef RB_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

  logic [CntW-1:0]    cnt_q;
  logic               cnt_run;
  logic               lock_timeout_q;
  logic [NUM_REQ-1:0] block_q;

  // Idle time is counted only while the owner has nothing pending.
  assign cnt_run       = lock_hold & ~(|(slot_full_q & owner_oh));
  assign force_release = cnt_run & (cnt_q == CntW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetb) begin
      cnt_q          <= '0;
      lock_timeout_q <= 1'b0;
      block_q        <= '0;
    end else begin
      lock_timeout_q <= force_release;
      if (!lock_valid_q || force_release || (grant && (|(pick_oh & owner_oh)))) begin
        cnt_q <= '0;
      end else if (cnt_run) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      // A timed-out owner must drop req_lock before it can lock again.
      block_q <= (block_q & req_lock) | (force_release ? owner_oh : '0);
    end
  end

  assign lock_block   = block_q;
  assign lock_timeout = lock_timeout_q;
`else
  assign force_release = 1'b0;
  assign lock_block    = '0;
  assign lock_timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q         <= StIdle;
      slot_full_q     <= '0;
      slot_we_q       <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr_q[i]  <= '0;
        slot_wdata_q[i] <= '0;
      end
      ptr_q           <= '0;
      winner_q        <= '0;
      win_we_q        <= 1'b0;
      lock_valid_q    <= 1'b0;
      lock_owner_q    <= '0;
      req_ack_q       <= '0;
      req_overflow_q  <= '0;
      req_rdata_q     <= '0;
      rb_address_q    <= '0;
      rb_data_write_q <= '0;
      rb_reg_en_q     <= 1'b0;
      rb_write_en_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_full_q    <= slot_full_d;
      req_overflow_q <= overflow_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          slot_addr_q[i]  <= req_addr[i*ADDR_W +: ADDR_W];
          slot_wdata_q[i] <= req_wdata[i*DATA_W +: DATA_W];
          slot_we_q[i]    <= req_we[i];
        end
      end

      lock_valid_q <= lock_valid_d;
      if (lock_acquire) lock_owner_q <= pick;

      if (grant) begin
        winner_q        <= pick;
        ptr_q           <= ptr_next;
        win_we_q        <= pick_we;
        rb_address_q    <= pick_addr;
        rb_data_write_q <= pick_wdata;
        rb_write_en_q   <= pick_we;
        rb_reg_en_q     <= 1'b1;
      end else if (state_q == StIssue) begin
        rb_reg_en_q   <= 1'b0;
        rb_write_en_q <= 1'b0;
      end

      req_ack_q <= '0;
      if (state_q == StCapture) begin
        req_ack_q <= win_oh;
        if (!win_we_q) req_rdata_q <= rb_data_read;
      end
    end
  end

  assign req_ack       = req_ack_q;
  assign req_rdata     = req_rdata_q;
  assign req_overflow  = req_overflow_q;
  assign rb_address    = rb_address_q;
  assign rb_data_write = rb_data_write_q;
  assign rb_reg_en     = rb_reg_en_q;
  assign rb_write_en   = rb_write_en_q;
  assign grant_id      = winner_q;
  assign lock_valid    = lock_valid_q;

endmodule

// File: tb/tb_rb_bus_arbiter.sv
// Directed self-checking bench for rb_bus_arbiter (2 requesters, 8-bit address/data).
module tb_rb_bus_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;

  logic                      clk;
  logic                      resetb;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_en;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        req_overflow;
  logic [ADDR_W-1:0]         rb_address;
  logic [DATA_W-1:0]         rb_data_write;
  logic                      rb_reg_en;
  logic                      rb_write_en;
  logic [DATA_W-1:0]         rb_data_read;
  logic [1:0]                grant_id;
  logic                      lock_valid;
  logic                      lock_timeout;

  int total = 0;
  int bad   = 0;

  rb_bus_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .LOCK_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_en       (req_en),
    .req_we       (req_we),
    .req_lock     (req_lock),
    .req_ack      (req_ack),
    .req_rdata    (req_rdata),
    .req_overflow (req_overflow),
    .rb_address   (rb_address),
    .rb_data_write(rb_data_write),
    .rb_reg_en    (rb_reg_en),
    .rb_write_en  (rb_write_en),
    .rb_data_read (rb_data_read),
    .grant_id     (grant_id),
    .lock_valid   (lock_valid),
    .lock_timeout (lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int i, input logic [7:0] a, input logic [7:0] d, input logic we);
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_we[i]                     = we;
    req_en[i]                     = 1'b1;
  endtask

  task automatic test_reset();
    resetb       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_en       = '0;
    req_we       = '0;
    req_lock     = '0;
    rb_data_read = '0;
    step();
    step();
    total++;
    if ({req_ack, req_overflow, rb_reg_en, rb_write_en} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 000000",
               {req_ack, req_overflow, rb_reg_en, rb_write_en});
    end
    total++;
    if ({grant_id, lock_valid, lock_timeout} !== 4'b0) begin
      bad++;
      $display("FAIL reset_status: got %b want 0000", {grant_id, lock_valid, lock_timeout});
    end
    total++;
    if ({req_rdata, rb_address, rb_data_write} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 000000", {req_rdata, rb_address, rb_data_write});
    end
    resetb = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    rb_data_read = 8'hA5;
    strobe(0, 8'h05, 8'h00, 1'b0);
    step();                               // T+1
    req_en = '0;
    step();                               // T+2
    total++;
    if ({rb_reg_en, rb_write_en, grant_id} !== 4'b1000) begin
      bad++;
      $display("FAIL read_issue: got %b want 1000", {rb_reg_en, rb_write_en, grant_id});
    end
    total++;
    if (rb_address !== 8'h05) begin
      bad++;
      $display("FAIL read_addr: got %h want 05", rb_address);
    end
    step();                               // T+3
    total++;
    if ({rb_reg_en, req_ack} !== 3'b000) begin
      bad++;
      $display("FAIL read_capture: got %b want 000", {rb_reg_en, req_ack});
    end
    step();                               // T+4
    total++;
    if (req_ack !== 2'b01 || req_rdata !== 8'hA5) begin
      bad++;
      $display("FAIL read_ack: got ack=%b rdata=%h want ack=01 rdata=a5", req_ack, req_rdata);
    end
    step();
    total++;
    if (req_ack !== 2'b00) begin
      bad++;
      $display("FAIL read_ack_pulse: got %b want 00", req_ack);
    end
  endtask

  task automatic test_single_write();
    rb_data_read = 8'hEE;
    strobe(1, 8'h3C, 8'h5A, 1'b1);
    step();
    req_en = '0;
    step();                               // T+2
    total++;
    if ({rb_reg_en, rb_write_en, grant_id} !== 4'b1101 || rb_address !== 8'h3C
        || rb_data_write !== 8'h5A) begin
      bad++;
      $display("FAIL write_issue: got en/we/id=%b addr=%h data=%h want 1101 3c 5a",
               {rb_reg_en, rb_write_en, grant_id}, rb_address, rb_data_write);
    end
    step();
    step();                               // T+4
    total++;
    if (req_ack !== 2'b10 || req_rdata !== 8'hA5) begin
      bad++;
      $display("FAIL write_ack: got ack=%b rdata=%h want ack=10 rdata=a5", req_ack, req_rdata);
    end
    step();
  endtask

  task automatic test_simultaneous();
    rb_data_read = 8'h11;
    strobe(0, 8'h21, 8'h00, 1'b0);
    strobe(1, 8'h22, 8'h00, 1'b0);
    step();
    req_en = '0;
    step();                               // T+2
    total++;
    if (rb_reg_en !== 1'b1 || grant_id !== 2'd0 || rb_address !== 8'h21) begin
      bad++;
      $display("FAIL simul_first: got en=%b id=%0d addr=%h want 1 0 21",
               rb_reg_en, grant_id, rb_address);
    end
    step();
    step();                               // T+4
    total++;
    if (req_ack !== 2'b01 || req_rdata !== 8'h11) begin
      bad++;
      $display("FAIL simul_ack0: got ack=%b rdata=%h want 01 11", req_ack, req_rdata);
    end
    rb_data_read = 8'h22;
    step();                               // T+5
    total++;
    if (rb_reg_en !== 1'b1 || grant_id !== 2'd1 || rb_address !== 8'h22) begin
      bad++;
      $display("FAIL simul_second: got en=%b id=%0d addr=%h want 1 1 22",
               rb_reg_en, grant_id, rb_address);
    end
    step();
    step();                               // T+7
    total++;
    if (req_ack !== 2'b10 || req_rdata !== 8'h22) begin
      bad++;
      $display("FAIL simul_ack1: got ack=%b rdata=%h want 10 22", req_ack, req_rdata);
    end
    step();
  endtask

  task automatic test_overflow();
    int n_en;
    int n_ovf;
    rb_data_read = 8'h99;
    strobe(1, 8'h40, 8'h00, 1'b0);
    step();                               // T+1: slot 1 pending, not issued
    strobe(1, 8'h41, 8'h00, 1'b0);
    step();                               // T+2
    req_en = '0;
    total++;
    if (req_overflow !== 2'b10 || rb_reg_en !== 1'b1 || rb_address !== 8'h40) begin
      bad++;
      $display("FAIL ovf_pulse: got ovf=%b en=%b addr=%h want 10 1 40",
               req_overflow, rb_reg_en, rb_address);
    end
    n_en  = 0;
    n_ovf = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (rb_reg_en) n_en++;
      if (req_overflow != 2'b00) n_ovf++;
    end
    total++;
    if (n_en != 0 || n_ovf != 0) begin
      bad++;
      $display("FAIL ovf_dropped: got extra_issues=%0d extra_ovf=%0d want 0 0", n_en, n_ovf);
    end
  endtask

  task automatic test_lock();
    logic [7:0] rec_addr [8];
    logic [7:0] rec_data [8];
    logic       rec_we   [8];
    int         rec_cyc  [8];
    logic [7:0] exp_addr [5];
    int         n;
    exp_addr[0] = 8'h10;
    exp_addr[1] = 8'h11;
    exp_addr[2] = 8'h12;
    exp_addr[3] = 8'h13;
    exp_addr[4] = 8'h77;
    n = 0;
    rb_data_read = 8'h3E;
    for (int c = 0; c < 19; c++) begin
      req_en = '0;
      case (c)
        0: begin
          req_lock[0] = 1'b1;
          strobe(0, 8'h10, 8'hA0, 1'b1);
          strobe(1, 8'h77, 8'h00, 1'b0);
        end
        2:  strobe(0, 8'h11, 8'hA1, 1'b1);
        5:  strobe(0, 8'h12, 8'hA2, 1'b1);
        8:  strobe(0, 8'h13, 8'hA3, 1'b1);
        14: req_lock[0] = 1'b0;
        default: ;
      endcase
      if (rb_reg_en && n < 8) begin
        rec_addr[n] = rb_address;
        rec_data[n] = rb_data_write;
        rec_we[n]   = rb_write_en;
        rec_cyc[n]  = c;
        n++;
      end
      if (c == 1 || c == 2 || c == 14 || c == 15) begin
        total++;
        if (lock_valid !== ((c == 2 || c == 14) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL lock_valid_c%0d: got %b want %b", c, lock_valid,
                   (c == 2 || c == 14) ? 1'b1 : 1'b0);
        end
      end
      if (c == 17) begin
        total++;
        if (req_ack !== 2'b10 || req_rdata !== 8'h3E) begin
          bad++;
          $display("FAIL lock_ack1: got ack=%b rdata=%h want 10 3e", req_ack, req_rdata);
        end
      end
      step();
    end
    req_en   = '0;
    req_lock = '0;
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL lock_issue_count: got %0d want 5", n);
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (rec_addr[k] !== exp_addr[k] || rec_we[k] !== (k < 4)
            || (k < 4 && rec_data[k] !== (8'hA0 + 8'(k)))) begin
          bad++;
          $display("FAIL lock_issue%0d: got addr=%h we=%b data=%h want addr=%h we=%b",
                   k, rec_addr[k], rec_we[k], rec_data[k], exp_addr[k], k < 4);
        end
      end
      total++;
      if (rec_cyc[4] != 15) begin
        bad++;
        $display("FAIL lock_release_issue: got cycle %0d want 15", rec_cyc[4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_evt;
    rb_data_read = 8'h5C;
    strobe(0, 8'h30, 8'h00, 1'b0);
    step();
    req_en = '0;
    step();                               // T+2: ISSUE
    total++;
    if (rb_reg_en !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_issue: got %b want 1", rb_reg_en);
    end
    resetb = 1'b0;
    step();
    total++;
    if ({req_ack, req_overflow, rb_reg_en, rb_write_en, grant_id, lock_valid, lock_timeout} !== 10'b0
        || {req_rdata, rb_address, rb_data_write} !== 24'h0) begin
      bad++;
      $display("FAIL rstmid_outputs: got ctl=%b data=%h want 0",
               {req_ack, req_overflow, rb_reg_en, rb_write_en, grant_id, lock_valid, lock_timeout},
               {req_rdata, rb_address, rb_data_write});
    end
    resetb = 1'b1;
    n_evt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rb_reg_en || req_ack != 2'b00) n_evt++;
    end
    total++;
    if (n_evt != 0) begin
      bad++;
      $display("FAIL rstmid_aborted: got %0d events want 0", n_evt);
    end
    // Slot 0 must be empty: a fresh strobe is accepted without overflow.
    strobe(0, 8'h31, 8'h00, 1'b0);
    step();
    req_en = '0;
    step();
    total++;
    if (req_overflow !== 2'b00 || rb_reg_en !== 1'b1 || rb_address !== 8'h31) begin
      bad++;
      $display("FAIL rstmid_slot_empty: got ovf=%b en=%b addr=%h want 00 1 31",
               req_overflow, rb_reg_en, rb_address);
    end
    step();
    step();
    step();
  endtask

`ifdef RB_ARB_LOCK_TIMEOUT_EN
  task automatic test_lock_timeout();
    rb_data_read = 8'h00;
    for (int c = 0; c < 26; c++) begin
      req_en = '0;
      case (c)
        0: begin
          req_lock[0] = 1'b1;
          strobe(0, 8'h50, 8'hB0, 1'b1);
        end
        1:  strobe(1, 8'h66, 8'h00, 1'b0);
        20: strobe(0, 8'h51, 8'hB1, 1'b1);
        default: ;
      endcase
      if (c == 18 || c == 19 || c == 20) begin
        total++;
        if ({lock_timeout, lock_valid} !== ((c == 19) ? 2'b10 : (c == 18) ? 2'b01 : 2'b00)) begin
          bad++;
          $display("FAIL timeout_c%0d: got to/valid=%b want %b", c, {lock_timeout, lock_valid},
                   (c == 19) ? 2'b10 : (c == 18) ? 2'b01 : 2'b00);
        end
      end
      if (c == 20) begin
        total++;
        if (rb_reg_en !== 1'b1 || grant_id !== 2'd1 || rb_address !== 8'h66) begin
          bad++;
          $display("FAIL timeout_grant1: got en=%b id=%0d addr=%h want 1 1 66",
                   rb_reg_en, grant_id, rb_address);
        end
      end
      if (c == 24) begin
        total++;
        if (lock_valid !== 1'b0) begin
          bad++;
          $display("FAIL timeout_no_relock: got %b want 0", lock_valid);
        end
      end
      step();
    end
    req_en   = '0;
    req_lock = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_overflow();
    test_lock();
    test_reset_mid();
`ifdef RB_ARB_LOCK_TIMEOUT_EN
    test_lock_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rb_bus_arbiter.md
Name: rb_bus_arbiter

Overview:
- Shares the single register-bank access port (address / write-data / reg_en / write_en / read-data) between NUM_REQ host interfaces, e.g. index 0 = UART, index 1 = I2C.
- Replaces OR-combining of the host buses, which is only safe while a single interface is active.
- Each host holds a one-deep pending slot; grants are round-robin, with optional exclusive lock for multi-byte streaming transactions.
- Sits between the host interfaces and the register bank.

Parameters:
- NUM_REQ, 2, number of requesting host interfaces (2..4).
- ADDR_W, 8, register address width.
- DATA_W, 8, register data width.
- LOCK_TIMEOUT, 1024, idle-cycle limit for a held lock (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- resetb  in  1  synchronous active-low reset.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i belongs to requester i.
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data.
- req_en  in  NUM_REQ  single-cycle access strobe.
- req_we  in  NUM_REQ  1 = write, 0 = read; qualified by req_en.
- req_lock  in  NUM_REQ  request or hold an exclusive lock.
- req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  DATA_W  read data, broadcast to all requesters; valid with req_ack.
- req_overflow  out  NUM_REQ  one-cycle pulse when a request is dropped.
- rb_address  out  ADDR_W  register-bank address.
- rb_data_write  out  DATA_W  register-bank write data.
- rb_reg_en  out  1  register-bank access strobe.
- rb_write_en  out  1  register-bank write qualifier.
- rb_data_read  in  DATA_W  register-bank read data, valid the cycle after rb_reg_en.
- grant_id  out  2  index of the last granted requester.
- lock_valid  out  1  a lock is currently held.
- lock_timeout  out  1  one-cycle pulse on a forced lock release.

Behaviour:
- Reset: resetb and clk are as already decided — reset resetb, synchronous, active-low; clock clk. On reset, all outputs go to 0, all pending slots are cleared, the FSM goes to IDLE, the round-robin pointer goes to 0 and any lock is dropped.
  - Reset asserted mid-access aborts the access: no req_ack is issued, and rb_reg_en is 0 from the next edge onward.
- Capture: on req_en[i], the address, write data and we for requester i are registered into slot i at the next edge.
  - A request is accepted if slot i is empty, or if slot i is freed in the same cycle (ISSUE cycle of requester i).
  - Otherwise the request is dropped and req_overflow[i] pulses on the next cycle.
- FSM states:
  - IDLE: if any eligible slot is full, latch the winner, load the rb_* registers and go to ISSUE. If no slot is full, stay in IDLE.
  - ISSUE: rb_reg_en = 1 and rb_write_en = winner's we for exactly this cycle. The winner's slot is freed at the end of this cycle. Always go to CAPTURE.
  - CAPTURE: rb_reg_en = 0. Register rb_data_read into req_rdata (reads only; req_rdata holds its value on writes). Set req_ack[winner] for the following cycle. Go to IDLE.
- Timing: req_en at cycle T gives pending at T+1 (IDLE arbitration), rb_reg_en at T+2, and req_ack/req_rdata at T+4.
  - IDLE at T+4 may arbitrate again, so back-to-back throughput is one access per 3 cycles.
- Arbitration:
  - Round-robin search starts at the pointer. After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
  - grant_id updates on entry to ISSUE.
- Lock:
  - Requester i acquires the lock when it is granted while req_lock[i] = 1; lock_valid = 1 from the next cycle.
  - While the lock is held, only the owner's slot is eligible. Other slots keep their pending requests and are not dropped.
  - The lock is released in the cycle after req_lock[owner] falls. req_lock from a non-owner has no effect until the lock is released.
- Simultaneous requests: concurrent req_en strobes are all captured into their slots. The winner is the first full slot at or after the pointer.

Optional Feature:
- Macro: RB_ARB_LOCK_TIMEOUT_EN.
- With the macro:
  - A counter runs while lock_valid = 1 and the owner's slot is empty. It clears on each grant to the owner.
  - When the counter reaches LOCK_TIMEOUT, the lock is force-released and lock_timeout pulses for one cycle.
  - The owner must deassert req_lock and reassert it to reacquire the lock.
- Without the macro: a lock is held indefinitely, lock_timeout is tied to 0 and no counter logic is built.

Test Plan:
- Single read: req_en[0], addr 0x05, rb_data_read = 0xA5 → rb_reg_en high at T+2 with rb_address = 0x05; req_ack[0] and req_rdata = 0xA5 at T+4.
- Simultaneous strobes: req_en[0] and req_en[1] together, pointer = 0 → grant_id 0 then 1; acks are 3 cycles apart; pointer ends at 0.
- Overflow: req_en[1] twice within 1 cycle while its slot is pending and not yet issued → req_overflow[1] pulses once; only the first access reaches the bank.
- Lock: requester 0 holds req_lock and issues 4 writes while requester 1 has a request pending → 4 bank writes from requester 0, then requester 1's request is issued the cycle after req_lock[0] falls.
- Reset mid-access: resetb low during ISSUE → no req_ack; all outputs 0; the slot is empty after reset.
- RB_ARB_LOCK_TIMEOUT_EN with LOCK_TIMEOUT = 16: owner holds the lock idle → lock_timeout pulses after 16 cycles, then lock_valid = 0 and requester 1 is granted.
